// File: rtl/fft_peak_pkg.sv
// Shared constants, FSM encoding and pipeline tag layout for the FFT peak detector.
package fft_peak_pkg;

   localparam int DATA_W    = 12;
   localparam int LOG2_PTS  = 10;
   localparam int MAG_W     = 2 * DATA_W;
   localparam int ENERGY_W  = MAG_W + LOG2_PTS;
   localparam int FLUSH_CYC = 3;

   localparam logic [LOG2_PTS-1:0] LAST_BIN = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Side information that rides alongside each bin through the magnitude pipeline.
   // start: first bin of a frame, restart the running peak
   // fin:   last bin of a frame, publish the result or the error
   // bad:   frame integrity failed (only meaningful with fin)
   // abort: a previous frame was cut short by this bin's sop
   typedef struct packed {
      logic [LOG2_PTS-1:0] bin;
      logic                elig;
      logic                start;
      logic                fin;
      logic                bad;
      logic                abort;
   } tag_t;

   function automatic logic bin_eligible(input logic [LOG2_PTS-1:0] bin,
                                         input bit skip_dc,
                                         input bit half_spec);
      return !((skip_dc && (bin == '0)) || (half_spec && bin[LOG2_PTS-1]));
   endfunction

endpackage

// File: rtl/fft_peak_detect_mag_sq.sv
// Two-stage pipelined signed re^2 + im^2 with a valid/tag passthrough.
module fft_mag_sq #(
   parameter int IN_W  = 12,
   parameter int TAG_W = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [TAG_W-1:0]       in_tag,
   input  logic signed [IN_W-1:0] re,
   input  logic signed [IN_W-1:0] im,
   output logic                   out_valid,
   output logic [TAG_W-1:0]       out_tag,
   output logic [2*IN_W-1:0]      mag
);

   localparam int OUT_W = 2 * IN_W;

   logic signed [OUT_W-1:0] re_x;
   logic signed [OUT_W-1:0] im_x;
   logic [OUT_W-1:0]        sq_re;
   logic [OUT_W-1:0]        sq_im;
   logic                    s1_valid;
   logic [TAG_W-1:0]        s1_tag;

   // Sign-extend before squaring so the product is formed at full width.
   assign re_x = OUT_W'(re);
   assign im_x = OUT_W'(im);

   // Stage 1: square each component; squares are non-negative so they are kept unsigned.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_tag   <= '0;
         sq_re    <= '0;
         sq_im    <= '0;
      end else begin
         s1_valid <= in_valid;
         s1_tag   <= in_tag;
         sq_re    <= $unsigned(re_x * re_x);
         sq_im    <= $unsigned(im_x * im_x);
      end
   end

   // Stage 2: sum; the largest case 2*2048^2 = 2^23 still fits in OUT_W bits.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_tag   <= '0;
         mag       <= '0;
      end else begin
         out_valid <= s1_valid;
         out_tag   <= s1_tag;
         mag       <= sq_re + sq_im;
      end
   end

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame peak-bin detector on the FFT core's Avalon-ST source stream.
// Optional build macro FFT_PEAK_ENERGY_EN adds frame_energy, the sum of
// eligible-bin magnitudes, published alongside peak_valid.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready, waiting for sop; beats without sop are dropped
// FRAME | collecting bins, bin index advances per accepted beat
// FLUSH | ready low for FLUSH_CYC cycles while the pipeline drains
module fft_peak_detect
   import fft_peak_pkg::*;
#(
   parameter int SKIP_DC   = 1,
   parameter int HALF_SPEC = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     src_valid,
   output logic                     src_ready,
   input  logic                     src_sop,
   input  logic                     src_eop,
   input  logic [1:0]               src_error,
   input  logic signed [DATA_W-1:0] src_real,
   input  logic signed [DATA_W-1:0] src_imag,
   output logic                     peak_valid,
   output logic [LOG2_PTS-1:0]      peak_bin,
   output logic [MAG_W-1:0]         peak_mag,
   output logic                     frame_err,
   output logic [15:0]              frame_cnt
`ifdef FFT_PEAK_ENERGY_EN
   ,
   output logic [ENERGY_W-1:0]      frame_energy
`endif
);

   state_t              state;
   state_t              state_nxt;
   logic [LOG2_PTS-1:0] bin_q;
   logic [LOG2_PTS-1:0] bin_nxt;
   logic [LOG2_PTS-1:0] beat_bin;
   logic                bad_q;
   logic                bad_nxt;
   logic [1:0]          flush_cnt;
   logic [1:0]          flush_nxt;
   logic                ready_nxt;
   logic                accept;
   logic                take;
   logic                last_idx;
   tag_t                tag_in;

   logic                mag_valid;
   tag_t                tag_out;
   logic [MAG_W-1:0]    mag;

   logic [LOG2_PTS-1:0] run_bin;
   logic [LOG2_PTS-1:0] base_bin;
   logic [LOG2_PTS-1:0] new_bin;
   logic [MAG_W-1:0]    run_mag;
   logic [MAG_W-1:0]    base_mag;
   logic [MAG_W-1:0]    new_mag;
   logic                better;

   assign accept = src_valid && src_ready;

   // Next-state, bin tracking and per-beat tag formation.
   always_comb begin
      state_nxt = state;
      bin_nxt   = bin_q;
      bad_nxt   = bad_q;
      flush_nxt = flush_cnt;
      take      = 1'b0;
      beat_bin  = '0;
      last_idx  = 1'b0;
      tag_in    = '0;
      case (state)
         IDLE, FRAME: begin
            if (accept && ((state == FRAME) || src_sop)) begin
               take         = 1'b1;
               beat_bin     = src_sop ? '0 : bin_q;
               last_idx     = (beat_bin == LAST_BIN);
               tag_in.bin   = beat_bin;
               tag_in.elig  = bin_eligible(beat_bin, SKIP_DC != 0, HALF_SPEC != 0);
               tag_in.start = src_sop;
               tag_in.abort = (state == FRAME) && src_sop;
               // A frame ends either on eop or on the last index; it is only
               // good when both coincide and no beat carried an error.
               tag_in.bad   = (!src_sop && bad_q) || (src_error != 2'b00) ||
                              (src_eop != last_idx);
               tag_in.fin   = src_eop || last_idx;
               bad_nxt      = tag_in.bad;
               bin_nxt      = beat_bin + 1'b1;
               if (tag_in.fin) begin
                  state_nxt = FLUSH;
                  flush_nxt = 2'(FLUSH_CYC - 1);
               end else begin
                  state_nxt = FRAME;
               end
            end
         end
         FLUSH: begin
            if (flush_cnt == '0) begin
               state_nxt = IDLE;
            end else begin
               flush_nxt = flush_cnt - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      ready_nxt = (state_nxt != FLUSH);
   end

   // FSM state, frame tracking and registered ready.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         bin_q     <= '0;
         bad_q     <= 1'b0;
         flush_cnt <= '0;
         src_ready <= 1'b0;
      end else begin
         state     <= state_nxt;
         bin_q     <= bin_nxt;
         bad_q     <= bad_nxt;
         flush_cnt <= flush_nxt;
         src_ready <= ready_nxt;
      end
   end

   fft_mag_sq #(
      .IN_W  (DATA_W),
      .TAG_W ($bits(tag_t))
   ) u_mag_sq (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (take),
      .in_tag    (tag_in),
      .re        (src_real),
      .im        (src_imag),
      .out_valid (mag_valid),
      .out_tag   (tag_out),
      .mag       (mag)
   );

   // Running-peak candidate: strict greater-than keeps the lowest bin on ties.
   always_comb begin
      base_bin = tag_out.start ? '0 : run_bin;
      base_mag = tag_out.start ? '0 : run_mag;
      better   = tag_out.elig && (mag > base_mag);
      new_bin  = better ? tag_out.bin : base_bin;
      new_mag  = better ? mag : base_mag;
   end

   // Running peak and published per-frame result / error pulses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         run_bin    <= '0;
         run_mag    <= '0;
         peak_valid <= 1'b0;
         peak_bin   <= '0;
         peak_mag   <= '0;
         frame_err  <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         peak_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (mag_valid) begin
            run_bin <= new_bin;
            run_mag <= new_mag;
            if (tag_out.abort) begin
               frame_err <= 1'b1;
            end
            if (tag_out.fin) begin
               if (tag_out.bad) begin
                  frame_err <= 1'b1;
               end else begin
                  peak_valid <= 1'b1;
                  peak_bin   <= new_bin;
                  peak_mag   <= new_mag;
                  frame_cnt  <= frame_cnt + 16'd1;
               end
            end
         end
      end
   end

`ifdef FFT_PEAK_ENERGY_EN
   logic [ENERGY_W-1:0] run_energy;
   logic [ENERGY_W-1:0] new_energy;

   // Energy accumulation over eligible bins, restarted on each frame's first bin.
   always_comb begin
      new_energy = (tag_out.start ? '0 : run_energy) +
                   (tag_out.elig ? ENERGY_W'(mag) : '0);
   end

   // Energy accumulator and published total, updated with good results only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         run_energy   <= '0;
         frame_energy <= '0;
      end else if (mag_valid) begin
         run_energy <= new_energy;
         if (tag_out.fin && !tag_out.bad) begin
            frame_energy <= new_energy;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect: a frame-level model collects each
// frame's bins, evaluates the peak when the frame ends, and schedules the
// expected pulse; a negedge process compares every output every cycle.
module tb_fft_peak_detect;
   import fft_peak_pkg::*;

   localparam int PTS  = 1 << LOG2_PTS;
   localparam int SKIP = 1;
   localparam int HALF = 1;

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic                     src_valid = 1'b0;
   logic                     src_ready;
   logic                     src_sop = 1'b0;
   logic                     src_eop = 1'b0;
   logic [1:0]               src_error = 2'b00;
   logic signed [DATA_W-1:0] src_real = '0;
   logic signed [DATA_W-1:0] src_imag = '0;
   logic                     peak_valid;
   logic [LOG2_PTS-1:0]      peak_bin;
   logic [MAG_W-1:0]         peak_mag;
   logic                     frame_err;
   logic [15:0]              frame_cnt;
`ifdef FFT_PEAK_ENERGY_EN
   logic [ENERGY_W-1:0]      frame_energy;
`endif

   fft_peak_detect #(.SKIP_DC(SKIP), .HALF_SPEC(HALF)) dut (
      .clk        (clk),
      .rst        (rst),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .src_sop    (src_sop),
      .src_eop    (src_eop),
      .src_error  (src_error),
      .src_real   (src_real),
      .src_imag   (src_imag),
      .peak_valid (peak_valid),
      .peak_bin   (peak_bin),
      .peak_mag   (peak_mag),
      .frame_err  (frame_err),
`ifdef FFT_PEAK_ENERGY_EN
      .frame_energy (frame_energy),
`endif
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int     due;
      bit     good;
      int     bin;
      longint mag;
      longint energy;
   } ev_t;

   ev_t    evq[$];
   int     checks = 0;
   int     failures = 0;
   bit     chk_en = 1'b0;
   int     ready_on = 1 << 30;
   int     fl_n = -100;
   bit     in_frame = 1'b0;
   int     idx = 0;
   bit     bad = 1'b0;
   int     fre[PTS];
   int     fim[PTS];
   int     vre[PTS];
   int     vim[PTS];
   int     m_bin = 0;
   longint m_mag = 0;
   int     m_cnt = 0;
   longint m_energy = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic bit ready_exp(input int c);
      return (c >= ready_on) && !((c >= fl_n) && (c <= fl_n + 2));
   endfunction

   function automatic bit eligible(input int k);
      return !((SKIP != 0) && (k == 0)) && !((HALF != 0) && (k >= PTS / 2));
   endfunction

   // Evaluate the collected frame bins 0..idx from first principles.
   task automatic frame_result(output int rb, output longint rm, output longint ren);
      longint m;
      rb = 0; rm = 0; ren = 0;
      for (int k = 0; k <= idx; k++) begin
         if (eligible(k)) begin
            m = longint'(fre[k]) * fre[k] + longint'(fim[k]) * fim[k];
            ren += m;
            if (m > rm) begin
               rm = m;
               rb = k;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0; src_error = 2'b00;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send(input bit sop, input bit eop, input logic [1:0] err,
                       input int re, input int im);
      int     e;
      int     rb;
      longint rm;
      longint ren;
      src_valid = 1'b1; src_sop = sop; src_eop = eop; src_error = err;
      src_real = re[DATA_W-1:0]; src_imag = im[DATA_W-1:0];
      e = cyc + 1;
      if (ready_exp(cyc) && (in_frame || sop)) begin
         if (sop) begin
            if (in_frame) evq.push_back('{e + 2, 1'b0, 0, 0, 0});
            in_frame = 1'b1; idx = 0; bad = 1'b0;
         end
         fre[idx] = re; fim[idx] = im;
         if (err != 2'b00) bad = 1'b1;
         if (eop || idx == PTS - 1) begin
            if (!(eop && idx == PTS - 1)) bad = 1'b1;
            frame_result(rb, rm, ren);
            evq.push_back('{e + 2, !bad, rb, rm, ren});
            in_frame = 1'b0;
            fl_n = e;
         end else begin
            idx++;
         end
      end
      @(posedge clk); #1;
      src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0; src_error = 2'b00;
   endtask

   task automatic run_frame(input int last, input bit with_eop, input int err_bin,
                            input logic [1:0] err_val, input bit gaps);
      for (int k = 0; k <= last; k++) begin
         if (gaps && $urandom_range(0, 7) == 0) idle(1);
         send(k == 0, with_eop && (k == last), (k == err_bin) ? err_val : 2'b00,
              vre[k], vim[k]);
      end
   endtask

   task automatic fill(input int re, input int im);
      for (int k = 0; k < PTS; k++) begin
         vre[k] = re; vim[k] = im;
      end
   endtask

   task automatic fill_rand();
      for (int k = 0; k < PTS; k++) begin
         vre[k] = ($urandom_range(0, 31) == 0) ? -2048 : int'($urandom_range(0, 4095)) - 2048;
         vim[k] = int'($urandom_range(0, 4095)) - 2048;
      end
   endtask

   task automatic reset_dut(input int n);
      rst = 1'b0;
      idle(1);
      evq.delete();
      in_frame = 1'b0; m_bin = 0; m_mag = 0; m_cnt = 0; m_energy = 0;
      ready_on = 1 << 30; fl_n = -100;
      chk_en = 1'b1;
      idle(n - 1);
      rst = 1'b1;
      ready_on = cyc + 1;
   endtask

   // Compare every output against the model's expectation on every cycle.
   always @(negedge clk) begin
      bit  e_pv;
      bit  e_fe;
      ev_t e;
      if (chk_en) begin
         e_pv = 1'b0;
         e_fe = 1'b0;
         while (evq.size() > 0 && evq[0].due <= cyc) begin
            e = evq.pop_front();
            if (e.good) begin
               e_pv = 1'b1;
               m_bin = e.bin; m_mag = e.mag; m_energy = e.energy;
               m_cnt = (m_cnt + 1) & 16'hFFFF;
            end else begin
               e_fe = 1'b1;
            end
         end
         chk("peak_valid", peak_valid, e_pv);
         chk("frame_err", frame_err, e_fe);
         chk("src_ready", src_ready, ready_exp(cyc));
         chk("peak_bin", peak_bin, m_bin);
         chk("peak_mag", peak_mag, m_mag);
         chk("frame_cnt", frame_cnt, m_cnt);
`ifdef FFT_PEAK_ENERGY_EN
         chk("frame_energy", frame_energy, m_energy);
`endif
      end
   end

   initial begin
      reset_dut(3);
      chk("reset_peak_bin", peak_bin, 0);
      chk("reset_peak_mag", peak_mag, 0);
      chk("reset_frame_cnt", frame_cnt, 0);
      idle(2);

      // Junk beats before any sop must be dropped.
      for (int k = 0; k < 5; k++) send(1'b0, k == 4, 2'b00, 2047, 2047);
      idle(3);

      // Single strong bin.
      fill(10, 10);
      vre[37] = 1000; vim[37] = -500;
      run_frame(PTS - 1, 1'b1, -1, 2'b00, 1'b0);
      // sop during FLUSH must be ignored.
      send(1'b1, 1'b0, 2'b00, 2047, 2047);
      idle(6);
      chk("t1_model_bin", m_bin, 37);
      chk("t1_model_mag", m_mag, 1250000);
      chk("t1_peak_bin", peak_bin, 37);
      chk("t1_peak_mag", peak_mag, 1250000);
      chk("t1_frame_cnt", frame_cnt, 1);

      // DC and upper-half bins are excluded.
      fill(0, 0);
      vre[0] = 2047; vim[0] = 2047;
      vre[600] = 2047; vim[600] = 2047;
      vre[5] = 100;
      run_frame(PTS - 1, 1'b1, -1, 2'b00, 1'b1);
      idle(6);
      chk("t2_model_bin", m_bin, 5);
      chk("t2_peak_bin", peak_bin, 5);
      chk("t2_peak_mag", peak_mag, 10000);

      // Tie at full-scale negative: lowest bin wins.
      fill(0, 0);
      vre[12] = -2048; vim[12] = -2048;
      vre[40] = -2048; vim[40] = -2048;
      run_frame(PTS - 1, 1'b1, -1, 2'b00, 1'b0);
      idle(6);
      chk("t3_model_mag", m_mag, 8388608);
      chk("t3_peak_bin", peak_bin, 12);
      chk("t3_peak_mag", peak_mag, 8388608);
      chk("t3_frame_cnt", frame_cnt, 3);

      // Early eop: error only, results held.
      fill_rand();
      run_frame(511, 1'b1, -1, 2'b00, 1'b0);
      idle(6);
      chk("t4_peak_bin", peak_bin, 12);
      chk("t4_peak_mag", peak_mag, 8388608);
      chk("t4_frame_cnt", frame_cnt, 3);

      // src_error on bin 200 spoils an otherwise good frame.
      fill_rand();
      run_frame(PTS - 1, 1'b1, 200, 2'b01, 1'b1);
      idle(6);
      chk("t5_frame_cnt", frame_cnt, 3);

      // Last index reached without eop.
      fill_rand();
      run_frame(PTS - 1, 1'b0, -1, 2'b00, 1'b0);
      idle(6);

      // Mid-frame sop: aborted frame errors, new frame completes.
      fill_rand();
      run_frame(99, 1'b0, -1, 2'b00, 1'b0);
      fill_rand();
      run_frame(PTS - 1, 1'b1, -1, 2'b00, 1'b1);
      idle(6);
      chk("t7_frame_cnt", frame_cnt, 4);

      // Random good frames.
      for (int f = 0; f < 3; f++) begin
         fill_rand();
         run_frame(PTS - 1, 1'b1, -1, 2'b00, 1'b1);
         idle(int'($urandom_range(4, 8)));
      end

      // Reset in the middle of a frame, then one good frame.
      fill_rand();
      run_frame(299, 1'b0, -1, 2'b00, 1'b0);
      reset_dut(2);
      idle(1);
      fill(3, -4);
      vre[77] = -1500; vim[77] = 900;
      run_frame(PTS - 1, 1'b1, -1, 2'b00, 1'b0);
      idle(10);
      chk("t9_peak_bin", peak_bin, 77);
      chk("t9_peak_mag", peak_mag, 3060000);
      chk("t9_frame_cnt", frame_cnt, 1);
      chk("pending_events", evq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
